vga_vram_arbiter: RTL and testbench

Single-port VRAM arbiter for the VGA text-mode display. It shares one on-chip 32-bit glyph-code RAM between two requesters. The Avalon-MM slave port (CPU text writes and reads) is one; the pixel-side character fetch engine, which must meet scanline deadlines, is the other. The arbiter sits between the Avalon interface logic and the RAM macro, and adds a read pipeline plus a starvation guard for the bus side.

---
 rtl/vga_vram_arbiter_if.sv | 51 +++++
 rtl/vga_vram_arbiter.sv | 89 ++++++++
 tb/tb_vga_vram_arbiter.sv | 286 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/vga_vram_arbiter_if.sv
// Signal bundle between the VRAM arbiter, its two requesters and the glyph RAM macro.
// The arbiter takes the slave view; the environment driving requests and modelling RAM takes master.
interface vga_vram_arbiter_if;
    logic        AVL_CS;
    logic        AVL_READ;
    logic        AVL_WRITE;
    logic [3:0]  AVL_BYTE_EN;
    logic [9:0]  AVL_ADDR;
    logic [31:0] AVL_WRITEDATA;
    logic        AVL_WAITREQUEST;
    logic [31:0] AVL_READDATA;
    logic        AVL_READDATAVALID;

    logic        FETCH_REQ;
    logic [9:0]  FETCH_ADDR;
    logic        FETCH_GNT;
    logic [31:0] FETCH_DATA;
    logic        FETCH_VALID;

    logic [9:0]  RAM_ADDR;
    logic        RAM_WE;
    logic [3:0]  RAM_BE;
    logic [31:0] RAM_WDATA;
    logic [31:0] RAM_RDATA;

    logic [15:0] FETCH_STALL_CNT;

    // Avalon: a command is accepted in a cycle where avl_req is high and AVL_WAITREQUEST
    // is low; the master holds every command signal until then. Fetch: FETCH_REQ and
    // FETCH_ADDR are held until the cycle FETCH_GNT is high. Both *VALID outputs are
    // single-cycle pulses delivered in grant order.
    modport slave (
        input  AVL_CS, AVL_READ, AVL_WRITE, AVL_BYTE_EN, AVL_ADDR, AVL_WRITEDATA,
        output AVL_WAITREQUEST, AVL_READDATA, AVL_READDATAVALID,
        input  FETCH_REQ, FETCH_ADDR,
        output FETCH_GNT, FETCH_DATA, FETCH_VALID,
        output RAM_ADDR, RAM_WE, RAM_BE, RAM_WDATA,
        input  RAM_RDATA,
        output FETCH_STALL_CNT
    );

    modport master (
        output AVL_CS, AVL_READ, AVL_WRITE, AVL_BYTE_EN, AVL_ADDR, AVL_WRITEDATA,
        input  AVL_WAITREQUEST, AVL_READDATA, AVL_READDATAVALID,
        output FETCH_REQ, FETCH_ADDR,
        input  FETCH_GNT, FETCH_DATA, FETCH_VALID,
        input  RAM_ADDR, RAM_WE, RAM_BE, RAM_WDATA,
        output RAM_RDATA,
        input  FETCH_STALL_CNT
    );
endinterface

// File: rtl/vga_vram_arbiter.sv
// Single-port glyph VRAM arbiter: fetch engine normally wins, Avalon is forced through
// after STARVE_LIMIT lost cycles; reads return through a two-stage pipeline.
module vga_vram_arbiter #(
    parameter int DEPTH        = 600,
    parameter int STARVE_LIMIT = 8
) (
    input  logic                CLK,
    input  logic                RESET,
    vga_vram_arbiter_if.slave   bus
);
    localparam int              WW       = $clog2(STARVE_LIMIT + 1);
    localparam logic [WW-1:0]   WAIT_MAX = WW'(STARVE_LIMIT);
    localparam logic [10:0]     DEPTH_W  = 11'(DEPTH);

    typedef enum logic { SRC_AVL = 1'b0, SRC_FETCH = 1'b1 } src_e;

    typedef struct packed {
        logic valid;
        src_e src;
        logic oob;
    } stage_t;

    logic          avl_req;
    logic          avl_rd;
    logic          avl_wr;
    logic          avl_gnt;
    logic          fetch_gnt;
    logic          avl_oob;
    logic          fetch_oob;
    logic          starved;
    logic [WW-1:0] wait_cnt;
    stage_t        s1;

    // A simultaneous read+write is a read; the write half is ignored.
    always_comb begin
        avl_req   = bus.AVL_CS & (bus.AVL_READ | bus.AVL_WRITE);
        avl_rd    = bus.AVL_READ;
        avl_wr    = bus.AVL_WRITE & ~bus.AVL_READ;
        starved   = (wait_cnt == WAIT_MAX);
        avl_gnt   = ~RESET & avl_req & (~bus.FETCH_REQ | starved);
        fetch_gnt = ~RESET & bus.FETCH_REQ & ~avl_gnt;
        avl_oob   = ({1'b0, bus.AVL_ADDR} >= DEPTH_W);
        fetch_oob = ({1'b0, bus.FETCH_ADDR} >= DEPTH_W);
    end

    assign bus.AVL_WAITREQUEST = RESET | (avl_req & ~avl_gnt);
    assign bus.FETCH_GNT       = fetch_gnt;
    assign bus.RAM_ADDR        = avl_gnt ? bus.AVL_ADDR : bus.FETCH_ADDR;
    assign bus.RAM_BE          = (avl_gnt & avl_wr) ? bus.AVL_BYTE_EN : 4'hF;
    assign bus.RAM_WDATA       = bus.AVL_WRITEDATA;
    assign bus.RAM_WE          = avl_gnt & avl_wr & (|bus.AVL_BYTE_EN) & ~avl_oob;

    // Stage 2 is the output register set itself: it captures RAM_RDATA one cycle
    // after stage 1 is loaded, giving the grant-to-valid latency of two cycles.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            wait_cnt              <= '0;
            s1                    <= '0;
            bus.AVL_READDATA      <= '0;
            bus.AVL_READDATAVALID <= 1'b0;
            bus.FETCH_DATA        <= '0;
            bus.FETCH_VALID       <= 1'b0;
            bus.FETCH_STALL_CNT   <= '0;
        end else begin
            if (~avl_req | avl_gnt) begin
                wait_cnt <= '0;
            end else if (!starved) begin
                wait_cnt <= wait_cnt + 1'b1;
            end

            s1.valid <= (avl_gnt & avl_rd) | fetch_gnt;
            s1.src   <= fetch_gnt ? SRC_FETCH : SRC_AVL;
            s1.oob   <= fetch_gnt ? fetch_oob : avl_oob;

            bus.AVL_READDATAVALID <= s1.valid & (s1.src == SRC_AVL);
            bus.FETCH_VALID       <= s1.valid & (s1.src == SRC_FETCH);
            if (s1.valid & (s1.src == SRC_AVL)) begin
                bus.AVL_READDATA <= s1.oob ? 32'h0 : bus.RAM_RDATA;
            end
            if (s1.valid & (s1.src == SRC_FETCH)) begin
                bus.FETCH_DATA <= s1.oob ? 32'h0 : bus.RAM_RDATA;
            end

            if (bus.FETCH_REQ & ~fetch_gnt & (bus.FETCH_STALL_CNT != 16'hFFFF)) begin
                bus.FETCH_STALL_CNT <= bus.FETCH_STALL_CNT + 16'd1;
            end
        end
    end
endmodule

// File: tb/tb_vga_vram_arbiter.sv
// Self-checking bench for vga_vram_arbiter: behavioural RAM, small arbitration model,
// and expected-data queues popped on each VALID pulse.
module tb_vga_vram_arbiter;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_errors = 0;
    logic rst_q = 1'b0;

    vga_vram_arbiter_if bus ();

    vga_vram_arbiter #(.DEPTH(600), .STARVE_LIMIT(8)) dut (
        .CLK   (clk),
        .RESET (rst),
        .bus   (bus)
    );

    // ---------------- clock / reset bookkeeping ----------------
    always #10 clk = ~clk;

    always @(posedge clk) begin
        cyc   <= cyc + 1;
        rst_q <= rst;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- behavioural RAM macro ----------------
    logic [31:0] mem [1024];

    always @(posedge clk) begin
        if (bus.RAM_WE) begin
            for (int i = 0; i < 4; i++) begin
                if (bus.RAM_BE[i]) mem[bus.RAM_ADDR][8*i +: 8] <= bus.RAM_WDATA[8*i +: 8];
            end
        end
        bus.RAM_RDATA <= mem[bus.RAM_ADDR];
    end

    // ---------------- checker ----------------
    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // ---------------- model and scoreboard state ----------------
    logic [31:0] ref_mem [1024];
    logic [63:0] exp_avl_q [$];
    logic [63:0] exp_fetch_q [$];
    logic [31:0] avl_hold = '0;
    logic [31:0] fetch_hold = '0;
    int          m_wait = 0;
    int          stall_model = 0;
    int          wait_obs = 0;
    logic        last_ag = 1'b0;
    logic        last_fg = 1'b0;

    // Output monitor: every VALID pulse pops its queue; data must hold otherwise.
    always @(negedge clk) begin
        logic [63:0] e;
        if (rst_q) begin
            avl_hold   = '0;
            fetch_hold = '0;
            check("rst_avl_valid", bus.AVL_READDATAVALID, 1'b0);
            check("rst_avl_data", bus.AVL_READDATA, 32'h0);
            check("rst_fetch_valid", bus.FETCH_VALID, 1'b0);
            check("rst_fetch_data", bus.FETCH_DATA, 32'h0);
            check("rst_stall_cnt", bus.FETCH_STALL_CNT, 16'h0);
        end else begin
            if (bus.AVL_READDATAVALID) begin
                if (exp_avl_q.size() == 0) begin
                    check("avl_unexpected_valid", 1'b1, 1'b0);
                end else begin
                    e = exp_avl_q.pop_front();
                    check("avl_rdata", bus.AVL_READDATA, e[31:0]);
                    check("avl_latency", cyc, e[63:32]);
                    avl_hold = e[31:0];
                end
            end else begin
                check("avl_hold", bus.AVL_READDATA, avl_hold);
            end
            if (bus.FETCH_VALID) begin
                if (exp_fetch_q.size() == 0) begin
                    check("fetch_unexpected_valid", 1'b1, 1'b0);
                end else begin
                    e = exp_fetch_q.pop_front();
                    check("fetch_data", bus.FETCH_DATA, e[31:0]);
                    check("fetch_latency", cyc, e[63:32]);
                    fetch_hold = e[31:0];
                end
            end else begin
                check("fetch_hold", bus.FETCH_DATA, fetch_hold);
            end
        end
    end

    // ---------------- driver ----------------
    task automatic drive(input logic a_rd, input logic a_wr, input logic [9:0] a_addr,
                         input logic [31:0] a_wd, input logic [3:0] a_be,
                         input logic f_req, input logic [9:0] f_addr);
        bus.AVL_CS        = a_rd | a_wr;
        bus.AVL_READ      = a_rd;
        bus.AVL_WRITE     = a_wr;
        bus.AVL_ADDR      = a_addr;
        bus.AVL_WRITEDATA = a_wd;
        bus.AVL_BYTE_EN   = a_be;
        bus.FETCH_REQ     = f_req;
        bus.FETCH_ADDR    = f_addr;
    endtask

    // One bus cycle: drive, check the combinational grant outputs against the model,
    // schedule expected read data, advance to the next negedge.
    task automatic step(input logic a_rd, input logic a_wr, input logic [9:0] a_addr,
                        input logic [31:0] a_wd, input logic [3:0] a_be,
                        input logic f_req, input logic [9:0] f_addr);
        logic a_req, ag, fg, a_is_wr, a_oob, f_oob, we;
        drive(a_rd, a_wr, a_addr, a_wd, a_be, f_req, f_addr);
        a_req   = a_rd | a_wr;
        ag      = a_req & (!f_req || m_wait == 8);
        fg      = f_req & !ag;
        a_is_wr = a_wr & !a_rd;
        a_oob   = (a_addr >= 10'd600);
        f_oob   = (f_addr >= 10'd600);
        we      = ag & a_is_wr & (|a_be) & !a_oob;
        #1;
        check("avl_waitreq", bus.AVL_WAITREQUEST, a_req & !ag);
        check("fetch_gnt", bus.FETCH_GNT, fg);
        check("ram_we", bus.RAM_WE, we);
        if (ag || fg) check("ram_addr", bus.RAM_ADDR, ag ? a_addr : f_addr);
        if (ag && a_is_wr) begin
            check("ram_be_wr", bus.RAM_BE, a_be);
            check("ram_wdata", bus.RAM_WDATA, a_wd);
        end else if (ag || fg) begin
            check("ram_be_rd", bus.RAM_BE, 4'hF);
        end
        if (bus.AVL_WAITREQUEST) wait_obs++;
        if (we) begin
            for (int i = 0; i < 4; i++) begin
                if (a_be[i]) ref_mem[a_addr][8*i +: 8] = a_wd[8*i +: 8];
            end
        end
        if (ag && a_rd) exp_avl_q.push_back({32'(cyc + 2), a_oob ? 32'h0 : ref_mem[a_addr]});
        if (fg) exp_fetch_q.push_back({32'(cyc + 2), f_oob ? 32'h0 : ref_mem[f_addr]});
        if (f_req && !fg) stall_model++;
        if (!a_req || ag) m_wait = 0;
        else if (m_wait < 8) m_wait++;
        last_ag = ag;
        last_fg = fg;
        @(posedge clk);
        @(negedge clk);
        check("stall_cnt", bus.FETCH_STALL_CNT, 16'(stall_model));
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 10'd0, 32'h0, 4'h0, 1'b0, 10'd0);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        logic        a_pend, f_pend, a_rd, a_wr, f_req;
        logic [9:0]  a_addr, f_addr;
        logic [31:0] a_wd;
        logic [3:0]  a_be;
        int          r;

        for (int i = 0; i < 1024; i++) ref_mem[i] = 32'h0;

        // Reset: grant outputs gated even with requests present.
        drive(1'b0, 1'b1, 10'd5, 32'h1, 4'hF, 1'b1, 10'd3);
        #1;
        check("reset_waitreq", bus.AVL_WAITREQUEST, 1'b1);
        check("reset_fetch_gnt", bus.FETCH_GNT, 1'b0);
        check("reset_ram_we", bus.RAM_WE, 1'b0);
        repeat (3) @(negedge clk);
        drive(1'b0, 1'b0, 10'd0, 32'h0, 4'h0, 1'b0, 10'd0);
        rst = 1'b0;

        // Preload the low words through the Avalon port.
        for (int i = 0; i < 16; i++) step(1'b0, 1'b1, 10'(i), $urandom, 4'hF, 1'b0, 10'd0);

        // Write then read, fetch idle.
        step(1'b0, 1'b1, 10'd5, 32'hDEADBEEF, 4'hF, 1'b0, 10'd0);
        step(1'b1, 1'b0, 10'd5, 32'h0, 4'h0, 1'b0, 10'd0);
        idle(3);

        // Byte enables, including an all-zero mask.
        step(1'b0, 1'b1, 10'd7, 32'h11223344, 4'hF, 1'b0, 10'd0);
        step(1'b0, 1'b1, 10'd7, 32'hAABBCCDD, 4'b0100, 1'b0, 10'd0);
        step(1'b1, 1'b0, 10'd7, 32'h0, 4'h0, 1'b0, 10'd0);
        step(1'b0, 1'b1, 10'd7, 32'hFFFFFFFF, 4'b0000, 1'b0, 10'd0);
        step(1'b1, 1'b0, 10'd7, 32'h0, 4'h0, 1'b0, 10'd0);
        idle(3);
        check("byte_merge_model", ref_mem[7], 32'h11BB3344);

        // Read and write together count as a read.
        step(1'b1, 1'b1, 10'd5, 32'h12345678, 4'hF, 1'b0, 10'd0);
        idle(3);

        // Interleaved fetch/Avalon reads, then back-to-back Avalon reads.
        step(1'b0, 1'b0, 10'd0, 32'h0, 4'h0, 1'b1, 10'd0);
        step(1'b1, 1'b0, 10'd2, 32'h0, 4'h0, 1'b0, 10'd0);
        step(1'b0, 1'b0, 10'd0, 32'h0, 4'h0, 1'b1, 10'd1);
        step(1'b1, 1'b0, 10'd3, 32'h0, 4'h0, 1'b0, 10'd0);
        for (int i = 8; i < 12; i++) step(1'b1, 1'b0, 10'(i), 32'h0, 4'h0, 1'b0, 10'd0);
        idle(3);

        // Out of range and the last valid word.
        step(1'b0, 1'b1, 10'd600, 32'hCAFEF00D, 4'hF, 1'b0, 10'd0);
        step(1'b1, 1'b0, 10'd600, 32'h0, 4'h0, 1'b0, 10'd0);
        step(1'b0, 1'b0, 10'd0, 32'h0, 4'h0, 1'b1, 10'd1023);
        step(1'b0, 1'b1, 10'd599, 32'h5A5AA5A5, 4'hF, 1'b0, 10'd0);
        step(1'b1, 1'b0, 10'd599, 32'h0, 4'h0, 1'b0, 10'd0);
        step(1'b0, 1'b0, 10'd0, 32'h0, 4'h0, 1'b1, 10'd599);
        idle(3);

        // Starvation guard under continuous fetch.
        wait_obs = 0;
        for (int i = 0; i < 9; i++) step(1'b1, 1'b0, 10'd5, 32'h0, 4'h0, 1'b1, 10'd4);
        check("starve_wait_cycles", wait_obs, 8);
        check("starve_grant_at_8", last_ag, 1'b1);
        check("starve_fetch_lost", last_fg, 1'b0);
        step(1'b0, 1'b0, 10'd0, 32'h0, 4'h0, 1'b1, 10'd4);
        idle(3);

        // Random mix with held commands.
        a_pend = 1'b0; f_pend = 1'b0;
        a_rd = 1'b0; a_wr = 1'b0; a_addr = '0; a_wd = '0; a_be = '0; f_req = 1'b0; f_addr = '0;
        for (int i = 0; i < 120; i++) begin
            if (!a_pend && $urandom_range(0, 2) != 0) begin
                a_pend = 1'b1;
                a_rd   = 1'($urandom_range(0, 1));
                a_wr   = !a_rd || ($urandom_range(0, 7) == 0);
                r      = $urandom_range(0, 9);
                a_addr = (r < 8) ? 10'($urandom_range(0, 15)) : 10'($urandom_range(600, 1023));
                a_wd   = $urandom;
                a_be   = 4'($urandom_range(0, 15));
            end
            if (!f_pend && $urandom_range(0, 3) != 0) begin
                f_pend = 1'b1;
                r      = $urandom_range(0, 9);
                f_addr = (r < 9) ? 10'($urandom_range(0, 15)) : 10'($urandom_range(600, 1023));
            end
            f_req = f_pend;
            if (a_pend) step(a_rd, a_wr, a_addr, a_wd, a_be, f_req, f_addr);
            else        step(1'b0, 1'b0, 10'd0, 32'h0, 4'h0, f_req, f_addr);
            if (last_ag) a_pend = 1'b0;
            if (last_fg) f_pend = 1'b0;
        end
        idle(4);

        // Reset the cycle after an Avalon read grant: the read must vanish.
        step(1'b1, 1'b0, 10'd5, 32'h0, 4'h0, 1'b0, 10'd0);
        rst = 1'b1;
        drive(1'b0, 1'b1, 10'd9, 32'h77777777, 4'hF, 1'b1, 10'd2);
        #1;
        check("midrst_waitreq", bus.AVL_WAITREQUEST, 1'b1);
        check("midrst_fetch_gnt", bus.FETCH_GNT, 1'b0);
        check("midrst_ram_we", bus.RAM_WE, 1'b0);
        exp_avl_q.delete();
        @(posedge clk);
        @(negedge clk);
        check("midrst_waitreq_held", bus.AVL_WAITREQUEST, 1'b1);
        @(posedge clk);
        @(negedge clk);
        drive(1'b0, 1'b0, 10'd0, 32'h0, 4'h0, 1'b0, 10'd0);
        rst         = 1'b0;
        m_wait      = 0;
        stall_model = 0;
        idle(3);
        step(1'b1, 1'b0, 10'd7, 32'h0, 4'h0, 1'b0, 10'd0);
        idle(4);

        check("avl_queue_drained", exp_avl_q.size(), 0);
        check("fetch_queue_drained", exp_fetch_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
